// File: rtl/taste_ereignis_if.sv
// ---------------------------------------------------------------------------
// taste_ereignis_if
// Signal bundle between a key debouncer / key-event decoder and the control
// logic consuming the events.
//   entprellt     debounced key level, 1 = pressed
//   gedrueckt     one-cycle pulse on press
//   losgelassen   one-cycle pulse on release
//   lang          one-cycle pulse when the long-press hold time is reached
//   wiederholung  one-cycle auto-repeat pulse while held after a long press
//   halten        level, 1 while the key is in a pressed state
// Modports:
//   master  supplies the key level, receives the events (debouncer side)
//   slave   the decoder: samples the key level, produces the events
// ---------------------------------------------------------------------------
interface taste_ereignis_if;
  logic entprellt;
  logic gedrueckt;
  logic losgelassen;
  logic lang;
  logic wiederholung;
  logic halten;

  modport master (
    output entprellt,
    input  gedrueckt,
    input  losgelassen,
    input  lang,
    input  wiederholung,
    input  halten
  );

  modport slave (
    input  entprellt,
    output gedrueckt,
    output losgelassen,
    output lang,
    output wiederholung,
    output halten
  );
endinterface

// File: rtl/taste_ereignis.sv
// ---------------------------------------------------------------------------
// taste_ereignis
// Key-event decoder: turns a debounced key level into registered one-cycle
// pulses for press, release, long press and (optionally) auto-repeat, plus a
// registered "key held" level. One instance per key.
//
// Parameters:
//   LONG_COUNT    hold time in clk cycles before 'lang' fires   (2 .. 2^26-1)
//   REPEAT_COUNT  auto-repeat period in clk cycles after 'lang' (2 .. 2^26-1)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   ev     taste_ereignis_if.slave (entprellt in; events and halten out)
// Build option:
//   TASTE_REPEAT_EN  defined: 'wiederholung' pulses every REPEAT_COUNT cycles
//                    while held after 'lang'. Undefined: 'wiederholung' is
//                    constant 0 and the counter rests at 0 in the long state.
// ---------------------------------------------------------------------------
module taste_ereignis #(
  parameter int LONG_COUNT   = 50_000_000,
  parameter int REPEAT_COUNT = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  taste_ereignis_if.slave  ev
);

  localparam int CNT_W   = 26;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (LONG_COUNT < 2 || LONG_COUNT > CNT_MAX ||
      REPEAT_COUNT < 2 || REPEAT_COUNT > CNT_MAX) begin : g_param_check
    $error("taste_ereignis: LONG_COUNT/REPEAT_COUNT outside 2 .. 2^26-1");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
`ifdef TASTE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             gedrueckt_q;
  logic             losgelassen_q;
  logic             lang_q;
  logic             wiederholung_q;
  logic             halten_q;

  // Falling level while held is a release; it takes priority over any
  // threshold hit that would coincide in the same cycle.
  logic release_hit;
  assign release_hit = !ev.entprellt && prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      prev           <= 1'b0;
      gedrueckt_q    <= 1'b0;
      losgelassen_q  <= 1'b0;
      lang_q         <= 1'b0;
      wiederholung_q <= 1'b0;
      halten_q       <= 1'b0;
    end else begin
      prev <= ev.entprellt;

      // NOTE: pulses default low here and are overridden below; with
      // non-blocking assignments the last write in the block wins, so each
      // pulse lasts exactly one cycle without a separate clear path.
      gedrueckt_q    <= 1'b0;
      losgelassen_q  <= 1'b0;
      lang_q         <= 1'b0;
      wiederholung_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (ev.entprellt && !prev) begin
            gedrueckt_q <= 1'b1;
            halten_q    <= 1'b1;
            cnt         <= '0;
            state       <= PRESSED;
          end
        end

        PRESSED: begin
          if (release_hit) begin
            losgelassen_q <= 1'b1;
            halten_q      <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else if (cnt == LONG_LAST) begin
            lang_q <= 1'b1;
            cnt    <= '0;
            state  <= LONG;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LONG: begin
          if (release_hit) begin
            losgelassen_q <= 1'b1;
            halten_q      <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else begin
`ifdef TASTE_REPEAT_EN
            if (cnt == REPEAT_LAST) begin
              wiederholung_q <= 1'b1;
              cnt            <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`else
            cnt <= '0;
`endif
          end
        end

        default: begin
          halten_q <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign ev.gedrueckt    = gedrueckt_q;
  assign ev.losgelassen  = losgelassen_q;
  assign ev.lang         = lang_q;
  assign ev.wiederholung = wiederholung_q;
  assign ev.halten       = halten_q;

endmodule

// File: tb/tb_taste_ereignis.sv
// ---------------------------------------------------------------------------
// tb_taste_ereignis
// Self-checking bench for taste_ereignis (LONG_COUNT=10, REPEAT_COUNT=4).
// Expected outputs come from a hold-age model: the number of edges since the
// press edge decides lang (age == LONG) and repeat (age past LONG by a
// multiple of REPEAT). Follows TASTE_REPEAT_EN like the design.
// ---------------------------------------------------------------------------
module tb_taste_ereignis;

  localparam int LONG   = 10;
  localparam int REPEAT = 4;
`ifdef TASTE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  taste_ereignis_if intf ();

  taste_ereignis #(
    .LONG_COUNT   (LONG),
    .REPEAT_COUNT (REPEAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ev    (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Model state
  bit m_held = 1'b0;
  int m_age  = 0;
  bit exp_g, exp_l, exp_lang, exp_w;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_held   = 1'b0;
    m_age    = 0;
    exp_g    = 1'b0;
    exp_l    = 1'b0;
    exp_lang = 1'b0;
    exp_w    = 1'b0;
  endtask

  task automatic model_edge(input bit lvl);
    exp_g    = 1'b0;
    exp_l    = 1'b0;
    exp_lang = 1'b0;
    exp_w    = 1'b0;
    if (!m_held) begin
      if (lvl) begin
        exp_g  = 1'b1;
        m_held = 1'b1;
        m_age  = 0;
      end
    end else if (!lvl) begin
      exp_l  = 1'b1;
      m_held = 1'b0;
    end else begin
      m_age++;
      if (m_age == LONG)
        exp_lang = 1'b1;
      else if (REP_EN && m_age > LONG && ((m_age - LONG) % REPEAT) == 0)
        exp_w = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int pulses;
    check({tag, ".gedrueckt"},    32'(intf.gedrueckt),    32'(exp_g));
    check({tag, ".losgelassen"},  32'(intf.losgelassen),  32'(exp_l));
    check({tag, ".lang"},         32'(intf.lang),         32'(exp_lang));
    check({tag, ".wiederholung"}, 32'(intf.wiederholung), 32'(exp_w));
    check({tag, ".halten"},       32'(intf.halten),       32'(m_held));
    pulses = int'(intf.gedrueckt) + int'(intf.losgelassen) +
             int'(intf.lang) + int'(intf.wiederholung);
    check({tag, ".onehot"}, 32'(pulses <= 1), 32'd1);
  endtask

  // Drive the level, take one rising edge, check #1 after it.
  task automatic step(input bit lvl, input string tag);
    intf.entprellt = lvl;
    @(posedge clk);
    edge_no++;
    model_edge(lvl);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input bit lvl, input int n, input string tag);
    for (int i = 0; i < n; i++) step(lvl, tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gedrueckt"},    32'(intf.gedrueckt),    32'd0);
    check({tag, ".losgelassen"},  32'(intf.losgelassen),  32'd0);
    check({tag, ".lang"},         32'(intf.lang),         32'd0);
    check({tag, ".wiederholung"}, 32'(intf.wiederholung), 32'd0);
    check({tag, ".halten"},       32'(intf.halten),       32'd0);
  endtask

  initial begin
    int lang_seen;
    int rep_seen;
    bit lvl;

    // Reset held with key pressed: outputs stay 0 while clocks run.
    rst_n          = 1'b0;
    intf.entprellt = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");

    // Release reset between edges: held key gives a fresh press.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, "rst_press");
    check("rst_press.gedrueckt_const", 32'(intf.gedrueckt), 32'd1);
    step(1'b1, "rst_hold");
    check("rst_hold.pulse_gone", 32'(intf.gedrueckt), 32'd0);
    check("rst_hold.halten_const", 32'(intf.halten), 32'd1);
    step(1'b0, "rst_rel");
    hold(1'b0, 3, "idle");

    // Short press of 5 cycles: no lang.
    hold(1'b1, 5, "short");
    step(1'b0, "short_rel");
    check("short_rel.losgelassen_const", 32'(intf.losgelassen), 32'd1);
    hold(1'b0, 2, "idle");

    // Long press, 25 cycles: lang at 10, repeats at 14/18/22 if enabled.
    lang_seen = 0;
    rep_seen  = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, "long");
      lang_seen += int'(intf.lang);
      rep_seen  += int'(intf.wiederholung);
    end
    step(1'b0, "long_rel");
    check("long.lang_count", 32'(lang_seen), 32'd1);
    check("long.rep_count",  32'(rep_seen),  REP_EN ? 32'd3 : 32'd0);
    hold(1'b0, 2, "idle");

    // Release on the edge where lang would fire.
    hold(1'b1, 10, "bnd_lang");
    step(1'b0, "bnd_lang_rel");
    check("bnd_lang_rel.lang_const", 32'(intf.lang), 32'd0);
    hold(1'b0, 2, "idle");

    // Release on the edge where the first repeat would fire.
    hold(1'b1, 14, "bnd_rep");
    step(1'b0, "bnd_rep_rel");
    check("bnd_rep_rel.rep_const", 32'(intf.wiederholung), 32'd0);
    hold(1'b0, 2, "idle");

    // Minimum spacing: press/release/press/release every cycle.
    for (int i = 0; i < 6; i++) step(1'(i % 2 == 0), "toggle");
    hold(1'b0, 2, "idle");

    // Asynchronous reset mid-hold (after edge 12 of the press).
    hold(1'b1, 13, "pre_arst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("arst_no_clock");
    rst_n = 1'b1;
    #1;
    lang_seen = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, "post_arst");
      if (intf.lang && lang_seen < 0) lang_seen = i;
    end
    check("post_arst.lang_offset", 32'(lang_seen), 32'd10);
    step(1'b0, "post_arst_rel");
    hold(1'b0, 2, "idle");

    // Randomised runs of random length, including single-cycle runs.
    lvl = 1'b0;
    for (int r = 0; r < 80; r++) begin
      int len;
      lvl = ~lvl;
      len = (($urandom % 4) == 0) ? 1 : int'($urandom_range(1, 30));
      hold(lvl, len, "rand");
    end
    hold(1'b0, 3, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taste_ereignis.md
# taste_ereignis

Key-event decoder that consumes the debounced, level-valid key signal from the debounce stage and turns it into single-cycle event pulses for the control logic: press, release, long-press and (optionally) auto-repeat. It sits between the per-key debouncer and any FSM that reacts to user input, so downstream logic never has to do its own edge detection or hold-time counting. All outputs are registered; one instance per key.

## Interface
- LONG_COUNT, 50000000: hold time in clk cycles before `lang` fires (1 s at 50 MHz); legal range 2 .. 2^26-1
- REPEAT_COUNT, 10000000: auto-repeat period in clk cycles after long-press (200 ms at 50 MHz); legal range 2 .. 2^26-1
- clk  input  1  system clock, 50 MHz, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- entprellt  input  1  debounced key level, 1 = pressed, synchronous to clk
- gedrueckt  output  1  one-cycle pulse on press
- losgelassen  output  1  one-cycle pulse on release
- lang  output  1  one-cycle pulse when hold reaches LONG_COUNT
- wiederholung  output  1  one-cycle pulse every REPEAT_COUNT cycles after `lang`, while still held
- halten  output  1  registered level, 1 while key is in a pressed state

## Operation
- Internal: `prev` (last sampled `entprellt`), 26-bit cycle counter `cnt`, state register {IDLE, PRESSED, LONG}.
- Reset (rst_n low, asynchronous): state IDLE, cnt = 0, prev = 0, all five outputs 0.
- Because prev resets to 0, a key held through reset release produces `gedrueckt` on the first clock edge after release (intended: downstream sees every held key).
- IDLE: on sample entprellt=1, prev=0 -> gedrueckt=1, halten=1, cnt=0, go PRESSED.
- PRESSED: cnt increments each cycle; when cnt == LONG_COUNT-1 and entprellt still 1 -> lang=1, cnt=0, go LONG.
- LONG: cnt increments; when cnt == REPEAT_COUNT-1 and entprellt still 1 -> wiederholung=1, cnt=0, stay LONG.
- Any pressed state, sample entprellt=0, prev=1 -> losgelassen=1, halten=0, cnt=0, go IDLE.
- Simultaneous release and threshold in the same cycle: release wins; no lang / wiederholung pulse.
- Pulse outputs are never high two consecutive cycles; at most one of gedrueckt/losgelassen/lang/wiederholung is high in any cycle.
- cnt never wraps: it is cleared on every threshold hit and on every state change.

## Timing
- Latency: event sampled at edge n -> pulse visible after edge n, cleared at edge n+1 (one register stage).
- Press first sampled at edge n: gedrueckt after n; lang after n+LONG_COUNT; k-th wiederholung after n+LONG_COUNT+k*REPEAT_COUNT.
- Release first sampled at edge m: losgelassen and halten=0 after m.
- Press held for exactly LONG_COUNT-1 cycles then released: no lang.
- Minimum press/release spacing of 1 cycle is handled correctly (no event lost), although the debouncer never delivers it.

## Configuration
- TASTE_REPEAT_EN defined: auto-repeat behaviour as above.
- TASTE_REPEAT_EN undefined: no repeat counter compare; wiederholung tied to 0; LONG holds with cnt frozen at 0 until release; REPEAT_COUNT ignored.

## Test plan
- Reset: hold rst_n=0 with entprellt=1, release -> gedrueckt=1 for exactly one cycle after the first edge, halten=1; during reset all outputs 0.
- Short press (LONG_COUNT=10, REPEAT_COUNT=4): entprellt high 5 cycles -> gedrueckt at edge 0, losgelassen at edge 5, no lang.
- Long press, repeat on: entprellt high 25 cycles from edge 0 -> lang at edge 10, wiederholung at 14, 18, 22, losgelassen at 25.
- Boundary: release sampled at the same edge the threshold would hit (edge 10) -> losgelassen only, no lang; likewise at edge 14 -> no wiederholung.
- Repeat off (TASTE_REPEAT_EN undefined): same 25-cycle press -> lang at 10, wiederholung never high, losgelassen at 25.
- Async reset mid-hold at edge 12: outputs drop to 0 immediately without a clock; after release with entprellt=1 -> fresh gedrueckt, lang 10 cycles later.
